// File: rtl/cursor_integrator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cursor_integrator: tilt samples -> bounded cursor position per tick.     |
// | Optional macro CURSOR_WRAP_EN: wrap at screen edges instead of clamping. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cursor_integrator #(
    parameter int AXIS_W   = 10,
    parameter int POS_W    = 11,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240,
    parameter int TICK_DIV = 10000000,
    parameter int SHIFT    = 3,
    parameter int DEADZONE = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [AXIS_W-1:0] x_axis,
    input  logic [AXIS_W-1:0] y_axis,
    input  logic              sample_valid,
    input  logic              hold,
    output logic [POS_W-1:0]  x_pos,
    output logic [POS_W-1:0]  y_pos,
    output logic              moved,
    output logic [3:0]        at_edge
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]  c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [AXIS_W-2:0] c_DZ        = (AXIS_W-1)'(DEADZONE);
    localparam logic [POS_W-1:0]  c_X_MAX     = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]  c_Y_MAX     = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0]  c_X_INIT    = POS_W'(X_INIT);
    localparam logic [POS_W-1:0]  c_Y_INIT    = POS_W'(Y_INIT);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SCALE = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick;
    logic              has_sample_q;
    logic [AXIS_W-1:0] hold_x_q, hold_y_q;
    logic [AXIS_W-1:0] snap_x_q, snap_y_q;
    logic [AXIS_W-2:0] step_x_q, step_y_q;
    logic              neg_x_q, neg_y_q;
    logic [POS_W-1:0]  x_pos_q, y_pos_q;
    logic [POS_W-1:0]  x_new, y_new;
    logic              moved_q;
    logic [3:0]        at_edge_q;
    logic              start_update;

    function automatic logic [AXIS_W-2:0] step_of(input logic [AXIS_W-1:0] s);
        logic [AXIS_W-1:0] mag_full;
        logic [AXIS_W-2:0] mag;
        mag_full = s[AXIS_W-1] ? -s : s;
        // Only the most negative sample still has its MSB set after negation.
        mag = mag_full[AXIS_W-1] ? {(AXIS_W-1){1'b1}} : mag_full[AXIS_W-2:0];
        if (mag <= c_DZ) begin
            return '0;
        end
        return mag >> SHIFT;
    endfunction

    function automatic logic [POS_W-1:0] apply_step(
        input logic [POS_W-1:0]  pos,
        input logic [AXIS_W-2:0] step,
        input logic              neg,
        input logic [POS_W-1:0]  max
    );
        logic signed [POS_W:0] p, st, lim, n;
`ifdef CURSOR_WRAP_EN
        logic signed [POS_W:0] one;
        one = (POS_W+1)'(1);
`endif
        p   = $signed({1'b0, pos});
        st  = $signed((POS_W+1)'(step));
        lim = $signed({1'b0, max});
        n   = neg ? (p - st) : (p + st);
`ifdef CURSOR_WRAP_EN
        if (n[POS_W]) begin
            n = n + lim + one;
        end else if (n > lim) begin
            n = n - lim - one;
        end
`else
        if (n[POS_W]) begin
            n = '0;
        end else if (n > lim) begin
            n = lim;
        end
`endif
        return n[POS_W-1:0];
    endfunction

    function automatic logic [3:0] edges_of(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
        return {x == '0, x == c_X_MAX, y == '0, y == c_Y_MAX};
    endfunction

    assign tick         = (cnt_q == c_TICK_LAST);
    assign start_update = tick && has_sample_q && !hold;
    assign x_new        = apply_step(x_pos_q, step_x_q, neg_x_q, c_X_MAX);
    assign y_new        = apply_step(y_pos_q, step_y_q, neg_y_q, c_Y_MAX);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:  if (start_update) state_d = S_SCALE;
            S_SCALE: state_d = S_APPLY;
            S_APPLY: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            has_sample_q <= 1'b0;
            hold_x_q     <= '0;
            hold_y_q     <= '0;
            snap_x_q     <= '0;
            snap_y_q     <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            neg_x_q      <= 1'b0;
            neg_y_q      <= 1'b0;
            x_pos_q      <= c_X_INIT;
            y_pos_q      <= c_Y_INIT;
            moved_q      <= 1'b0;
            at_edge_q    <= edges_of(c_X_INIT, c_Y_INIT);
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            moved_q <= 1'b0;
            if (sample_valid) begin
                hold_x_q     <= x_axis;
                hold_y_q     <= y_axis;
                has_sample_q <= 1'b1;
            end
            // The snapshot isolates the in-flight update from later captures.
            if (state_q == S_WAIT && start_update) begin
                snap_x_q <= hold_x_q;
                snap_y_q <= hold_y_q;
            end
            if (state_q == S_SCALE) begin
                step_x_q <= step_of(snap_x_q);
                step_y_q <= step_of(snap_y_q);
                neg_x_q  <= snap_x_q[AXIS_W-1];
                neg_y_q  <= snap_y_q[AXIS_W-1];
            end
            if (state_q == S_APPLY) begin
                x_pos_q   <= x_new;
                y_pos_q   <= y_new;
                at_edge_q <= edges_of(x_new, y_new);
                moved_q   <= (x_new != x_pos_q) || (y_new != y_pos_q);
            end
        end
    end

    assign x_pos   = x_pos_q;
    assign y_pos   = y_pos_q;
    assign moved   = moved_q;
    assign at_edge = at_edge_q;

endmodule
`default_nettype wire

// File: tb/tb_cursor_integrator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cursor_integrator: scoreboard bench, two instances (centre / near     |
// | right edge) sharing stimulus. Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_cursor_integrator;

    localparam int TDIV = 8;
    localparam int XMAX = 639;
    localparam int YMAX = 479;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] x_axis, y_axis;
    logic       sample_valid, hold;
    logic [10:0] x_pos0, y_pos0, x_pos1, y_pos1;
    logic        moved0, moved1;
    logic [3:0]  at_edge0, at_edge1;

    always #5 CLK = ~CLK;

    cursor_integrator #(.TICK_DIV(TDIV)) u_dut0 (
        .CLK(CLK), .RST(RST), .x_axis(x_axis), .y_axis(y_axis),
        .sample_valid(sample_valid), .hold(hold),
        .x_pos(x_pos0), .y_pos(y_pos0), .moved(moved0), .at_edge(at_edge0)
    );

    cursor_integrator #(.TICK_DIV(TDIV), .X_INIT(630)) u_dut1 (
        .CLK(CLK), .RST(RST), .x_axis(x_axis), .y_axis(y_axis),
        .sample_valid(sample_valid), .hold(hold),
        .x_pos(x_pos1), .y_pos(y_pos1), .moved(moved1), .at_edge(at_edge1)
    );

    typedef struct {
        int         due;
        int         x[2];
        int         y[2];
        logic       mv[2];
        logic [3:0] ed[2];
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ecount = 0;
    int m_cnt = 0;
    logic m_hs = 1'b0;
    logic [9:0] m_hx = '0, m_hy = '0;
    int mx[2], my[2];
    int cx[2], cy[2];
    logic [3:0] ced[2];
    localparam int XINIT[2] = '{320, 630};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int step_of(input logic [9:0] raw);
        int s, mag;
        s = $signed(raw);
        if (s < 0) mag = (s == -512) ? 511 : -s;
        else       mag = s;
        if (mag <= 4) return 0;
        return (s < 0) ? -(mag / 8) : (mag / 8);
    endfunction

    function automatic int move(input int pos, input int d, input int maxv);
        int n;
        n = pos + d;
`ifdef CURSOR_WRAP_EN
        if (n < 0) n = n + maxv + 1;
        else if (n > maxv) n = n - maxv - 1;
`else
        if (n < 0) n = 0;
        else if (n > maxv) n = maxv;
`endif
        return n;
    endfunction

    function automatic logic [3:0] edges(input int x, input int y);
        return {x == 0, x == XMAX, y == 0, y == YMAX};
    endfunction

    task automatic model_edge();
        exp_t e;
        logic tick;
        ecount++;
        if (RST) begin
            m_cnt = 0;
            m_hs  = 1'b0;
            m_hx  = '0;
            m_hy  = '0;
            exp_q.delete();
            for (int i = 0; i < 2; i++) begin
                mx[i] = XINIT[i]; my[i] = 240;
                cx[i] = XINIT[i]; cy[i] = 240;
                ced[i] = edges(XINIT[i], 240);
            end
        end else begin
            tick  = (m_cnt == TDIV - 1);
            m_cnt = (m_cnt + 1) % TDIV;
            if (tick && m_hs && !hold) begin
                e.due = ecount + 2;
                for (int i = 0; i < 2; i++) begin
                    e.x[i]  = move(mx[i], step_of(m_hx), XMAX);
                    e.y[i]  = move(my[i], step_of(m_hy), YMAX);
                    e.mv[i] = (e.x[i] != mx[i]) || (e.y[i] != my[i]);
                    e.ed[i] = edges(e.x[i], e.y[i]);
                    mx[i] = e.x[i];
                    my[i] = e.y[i];
                end
                exp_q.push_back(e);
            end
            if (sample_valid) begin
                m_hx = x_axis;
                m_hy = y_axis;
                m_hs = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        logic mv_exp[2];
        mv_exp[0] = 1'b0;
        mv_exp[1] = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 2; i++) begin
                cx[i] = e.x[i]; cy[i] = e.y[i]; ced[i] = e.ed[i];
                mv_exp[i] = e.mv[i];
            end
        end
        check_eq("x_pos0",   {21'b0, x_pos0},  cx[0]);
        check_eq("y_pos0",   {21'b0, y_pos0},  cy[0]);
        check_eq("moved0",   {31'b0, moved0},  {31'b0, mv_exp[0]});
        check_eq("at_edge0", {28'b0, at_edge0}, {28'b0, ced[0]});
        check_eq("x_pos1",   {21'b0, x_pos1},  cx[1]);
        check_eq("y_pos1",   {21'b0, y_pos1},  cy[1]);
        check_eq("moved1",   {31'b0, moved1},  {31'b0, mv_exp[1]});
        check_eq("at_edge1", {28'b0, at_edge1}, {28'b0, ced[1]});
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [9:0] xa, input logic [9:0] ya);
        x_axis       = xa;
        y_axis       = ya;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
    endtask

    // Leaves the bench positioned so that the coming cycle is a tick cycle.
    task automatic sync_tick();
        for (int i = 0; i < 2 * TDIV && m_cnt != TDIV - 1; i++) cycle();
    endtask

    initial begin
        RST = 1'b1; hold = 1'b0; sample_valid = 1'b0;
        x_axis = '0; y_axis = '0;
        run(3);
        RST = 1'b0;
        run(5 * TDIV);

        send(10'd40, 10'h3D8);
        run(3 * TDIV);

        send(10'd4, 10'h3FC);
        run(2 * TDIV);

        send(10'h200, 10'd511);
        run(3 * TDIV);

        send(10'd80, 10'd0);
        run(4 * TDIV);

        hold = 1'b1;
        send(10'h3B0, 10'd16);
        run(3 * TDIV);
        hold = 1'b0;
        run(TDIV);

        sync_tick();
        cycle();
        send(10'd160, 10'h3C0);
        run(2 * TDIV);

        sync_tick();
        cycle();
        cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        run(3 * TDIV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
